// File: rtl/trng_byte_packer.sv
// trng_byte_packer
//   Front end of the send controller. Raw TRNG bits arrive one per
//   bit_valid strobe. They are packed MSB-first into bytes, and each byte is
//   queued in a small synchronous FIFO. Bytes leave the FIFO one at a time
//   through the transmit / tx_byte / is_transmitting handshake. If a byte
//   completes while the FIFO is full, that byte is dropped. The drop is
//   recorded in the sticky overflow flag.
//
//   Optional feature macro: PACKER_STATS_EN
//     defined   -> drop_cnt output and a saturating 16-bit drop counter
//     undefined -> no drop_cnt port and no counter logic
//
// Parameters
//   DEPTH_LOG2       FIFO depth is 2**DEPTH_LOG2 bytes (1..8)
//
// Ports
//   clk              in   system clock, shared with the send controller
//   rst_n            in   asynchronous active-low reset
//   en               in   packing enable; low throws away the partial byte
//   bit_valid        in   raw bit strobe, one bit per high cycle
//   bit_in           in   raw bit, sampled when bit_valid is high
//   is_transmitting  in   busy flag from the send controller
//   transmit         out  one-cycle request to the send controller
//   tx_byte          out  byte being sent; held until the handshake completes
//   fifo_level       out  number of bytes currently queued
//   overflow         out  sticky; at least one completed byte was dropped
//   drop_cnt         out  dropped-byte count (PACKER_STATS_EN builds only)
//
// Handshake states
//   state | meaning
//   IDLE  | no request outstanding; pops the head byte when the FIFO is non-empty
//   REQ   | transmit is high for this single cycle
//   BUSY  | waiting for the send controller to raise is_transmitting
//   DONE  | waiting for is_transmitting to fall before the next request

module trng_byte_packer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  input  logic                  is_transmitting,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow
`ifdef PACKER_STATS_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = (DEPTH_LOG2)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Bit packing
  // ---------------------------------------------------------------------
  // Only seven bits need to be stored. On the eighth strobe, the finished
  // byte is formed from the stored bits plus the incoming bit. That byte
  // is written into the FIFO on the same edge.
  logic [6:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic [7:0] byte_new;

  assign byte_done = en && bit_valid && (bit_cnt == 3'd7);
  assign byte_new  = {shift_reg, bit_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (!en) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (bit_valid) begin
      bit_cnt   <= bit_cnt + 3'd1;
      shift_reg <= {shift_reg[5:0], bit_in};
    end
  end

  // ---------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  pop;
  logic                  push;
  logic                  full;
  logic                  drop;

  assign full = (fifo_level == LEVEL_FULL);
  // When the FIFO is full, a pop on the same edge frees the head slot.
  // The incoming byte then takes that slot instead of being dropped. The
  // pop reads the old head before the write lands, because both use
  // non-blocking updates.
  assign push = byte_done && (!full || pop);
  assign drop = byte_done && full && !pop;

  // Storage is not reset; contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= byte_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + LEVEL_ONE;
      end else if (pop && !push) begin
        fifo_level <= fifo_level - LEVEL_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef PACKER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------
  state_t     state;
  state_t     state_nxt;
  logic       transmit_nxt;
  logic [7:0] tx_byte_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      transmit <= 1'b0;
      tx_byte  <= '0;
    end else begin
      state    <= state_nxt;
      transmit <= transmit_nxt;
      tx_byte  <= tx_byte_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    transmit_nxt = 1'b0;
    tx_byte_nxt  = tx_byte;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          tx_byte_nxt  = mem[rd_ptr];
          transmit_nxt = 1'b1;
          pop          = 1'b1;
          state_nxt    = REQ;
        end
      end
      REQ: begin
        // The send controller raises is_transmitting only one cycle after
        // it samples transmit. For that reason, the flag is not checked in
        // this state.
        state_nxt = BUSY;
      end
      BUSY: begin
        if (is_transmitting) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!is_transmitting) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trng_byte_packer.sv
// tb_trng_byte_packer
//   Randomised and directed bench for trng_byte_packer (DEPTH_LOG2 = 2).
//   A queue-based reference model predicts transmit, tx_byte, fifo_level,
//   overflow and (with PACKER_STATS_EN) drop_cnt on every cycle. A simple
//   send-controller model answers each transmit pulse on is_transmitting.

module tb_trng_byte_packer;

  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en;
  logic          bit_valid;
  logic          bit_in;
  logic          is_transmitting;
  logic          transmit;
  logic [7:0]    tx_byte;
  logic [DL:0]   fifo_level;
  logic          overflow;
`ifdef PACKER_STATS_EN
  logic [15:0]   drop_cnt;
`endif

  trng_byte_packer #(.DEPTH_LOG2(DL)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .bit_valid       (bit_valid),
    .bit_in          (bit_in),
    .is_transmitting (is_transmitting),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .fifo_level      (fifo_level),
    .overflow        (overflow)
`ifdef PACKER_STATS_EN
    ,
    .drop_cnt        (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: a byte queue plus a request/ack handshake flag
  // ------------------------------------------------------------------
  logic [7:0] mq[$];
  logic [7:0] m_acc;
  int         m_nbits;
  logic       m_transmit;
  logic [7:0] m_tx;
  logic       m_ovf;
  int         m_drops;
  logic       m_ready;      // no request outstanding
  logic       m_skip;       // request cycle; ack not looked at yet
  logic       m_seen_busy;  // send controller has acknowledged

  task automatic model_reset();
    mq.delete();
    m_acc       = '0;
    m_nbits     = 0;
    m_transmit  = 1'b0;
    m_tx        = '0;
    m_ovf       = 1'b0;
    m_drops     = 0;
    m_ready     = 1'b1;
    m_skip      = 1'b0;
    m_seen_busy = 1'b0;
  endtask

  task automatic model_step();
    logic do_pop;
    do_pop = m_ready && (mq.size() != 0);
    m_transmit = 1'b0;
    if (do_pop) begin
      m_tx        = mq.pop_front();
      m_transmit  = 1'b1;
      m_ready     = 1'b0;
      m_skip      = 1'b1;
      m_seen_busy = 1'b0;
    end else if (!m_ready) begin
      if (m_skip) m_skip = 1'b0;
      else if (!m_seen_busy) m_seen_busy = is_transmitting;
      else if (!is_transmitting) m_ready = 1'b1;
    end
    if (!en) begin
      m_nbits = 0;
    end else if (bit_valid) begin
      m_acc = {m_acc[6:0], bit_in};
      m_nbits++;
      if (m_nbits == 8) begin
        m_nbits = 0;
        if (mq.size() < DEPTH) mq.push_back(m_acc);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ------------------------------------------------------------------
  // Per-cycle comparison and capture of transmitted bytes
  // ------------------------------------------------------------------
  logic [7:0] sent[$];
  int         tx_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      chk("transmit", {31'd0, transmit}, {31'd0, m_transmit});
      chk("tx_byte", {24'd0, tx_byte}, {24'd0, m_tx});
      chk("fifo_level", {{(31-DL){1'b0}}, fifo_level}, mq.size());
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef PACKER_STATS_EN
      chk("drop_cnt", {16'd0, drop_cnt}, m_drops);
`endif
      if (transmit === 1'b1) begin
        sent.push_back(tx_byte);
        tx_cyc.push_back(cyc);
      end
    end
  end

  // ------------------------------------------------------------------
  // Send controller model
  // ------------------------------------------------------------------
  int   busy_len  = 8;
  logic hold_busy = 1'b0;

  initial begin
    is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && transmit) begin
        @(posedge clk);
        #1;
        if (rst_n) is_transmitting = 1'b1;
        for (int i = 0; i < busy_len && rst_n; i++) @(posedge clk);
        while (hold_busy && rst_n) @(posedge clk);
        #1;
        is_transmitting = 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_in    = b[7-i];
      @(posedge clk);
      #1;
    end
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] sent_at(input int i);
    if (sent.size() > i) return {24'd0, sent[i]};
    return 32'hDEAD_BEEF;
  endfunction

  logic [7:0] exp_bytes[$];

  task automatic chk_sent(input string name);
    chk({name, "_count"}, sent.size(), exp_bytes.size());
    foreach (exp_bytes[i]) chk($sformatf("%s_byte%0d", name, i), sent_at(i), {24'd0, exp_bytes[i]});
  endtask

  // ------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------
  initial begin
    en        = 1'b1;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("reset_transmit", {31'd0, transmit}, 32'd0);
    chk("reset_level", {{(31-DL){1'b0}}, fifo_level}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);

    // 1: single byte B2
    sent.delete();
    send_bits(8'hB2, 8);
    tick(40);
    exp_bytes = '{8'hB2};
    chk_sent("t1");
    chk("t1_level", {{(31-DL){1'b0}}, fifo_level}, 32'd0);

    // 2: three bytes, 8-cycle busy each, gap >= 11
    sent.delete();
    tx_cyc.delete();
    busy_len = 8;
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    tick(80);
    exp_bytes = '{8'h11, 8'h22, 8'h33};
    chk_sent("t2");
    if (tx_cyc.size() == 3) begin
      chk("t2_gap01", {31'd0, (tx_cyc[1] - tx_cyc[0]) >= 11}, 32'd1);
      chk("t2_gap12", {31'd0, (tx_cyc[2] - tx_cyc[1]) >= 11}, 32'd1);
    end else begin
      chk("t2_pulses", tx_cyc.size(), 32'd3);
    end

    // 4: partial byte discarded by en=0
    sent.delete();
    send_bits(8'hE8, 5);
    en = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    tick(1);
    en = 1'b1; bit_valid = 1'b0;
    send_bits(8'hA5, 8);
    tick(40);
    exp_bytes = '{8'hA5};
    chk_sent("t4");

    // 3: overflow with link held busy
    do_reset();
    sent.delete();
    hold_busy = 1'b1;
    for (int i = 1; i <= 6; i++) send_bits(8'(i), 8);
    chk("t3_level", {{(31-DL){1'b0}}, fifo_level}, 32'd4);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_model_level", mq.size(), 32'd4);
    chk("t3_model_drops", m_drops, 32'd1);
`ifdef PACKER_STATS_EN
    chk("t3_drop_cnt", {16'd0, drop_cnt}, 32'd1);
`endif
    hold_busy = 1'b0;
    tick(100);
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk_sent("t3");

    // 5: push into a full FIFO on the same edge as a pop
    do_reset();
    sent.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) send_bits(8'h50 + 8'(i), 8);
    chk("t5_full", {{(31-DL){1'b0}}, fifo_level}, 32'd4);
    send_bits(8'h55, 7);
    hold_busy = 1'b0;
    begin
      int t;
      t = 0;
      while (is_transmitting && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("t5_release_timeout", {31'd0, is_transmitting}, 32'd0);
    end
    @(posedge clk); #1;
    bit_valid = 1'b1; bit_in = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0; bit_in = 1'b0;
    chk("t5_transmit", {31'd0, transmit}, 32'd1);
    chk("t5_level", {{(31-DL){1'b0}}, fifo_level}, 32'd4);
    chk("t5_overflow", {31'd0, overflow}, 32'd0);
    tick(100);
    exp_bytes = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    chk_sent("t5");

    // 6: async reset during DONE with two bytes queued
    do_reset();
    hold_busy = 1'b1;
    send_bits(8'h61, 8);
    send_bits(8'h62, 8);
    send_bits(8'h63, 8);
    chk("t6_pre_level", {{(31-DL){1'b0}}, fifo_level}, 32'd2);
    chk("t6_pre_tx_byte", {24'd0, tx_byte}, 32'h61);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_transmit", {31'd0, transmit}, 32'd0);
    chk("t6_async_tx_byte", {24'd0, tx_byte}, 32'd0);
    chk("t6_async_level", {{(31-DL){1'b0}}, fifo_level}, 32'd0);
    chk("t6_async_overflow", {31'd0, overflow}, 32'd0);
    hold_busy = 1'b0;
    sent.delete();
    tick(2);
    rst_n = 1'b1;
    tick(40);
    chk("t6_no_transmit", sent.size(), 32'd0);

    // Randomised traffic against the model
    for (int blk = 0; blk < 10; blk++) begin
      busy_len = $urandom_range(1, 12);
      for (int c = 0; c < 250; c++) begin
        en        = ($urandom_range(0, 49) != 0);
        bit_valid = ($urandom_range(0, 3) != 0);
        bit_in    = 1'($urandom_range(0, 1));
        tick(1);
      end
    end
    en        = 1'b1;
    bit_valid = 1'b0;
    tick(200);
    chk("rand_drained", {{(31-DL){1'b0}}, fifo_level}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
